// File: rtl/dmac_pkg.sv
// Shared types and encodings for the DMA controller main FSM.
package dmac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_CFG_ADDR,
        ST_CFG_DATA,
        ST_CH_START,
        ST_CH_RUN,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [1:0] IDX_SADDR = 2'd0;
    localparam logic [1:0] IDX_DADDR = 2'd1;
    localparam logic [1:0] IDX_SIZE  = 2'd2;
    localparam logic [1:0] IDX_CTRL  = 2'd3;

    localparam logic [1:0] CON_CH1 = 2'b00;
    localparam logic [1:0] CON_CH2 = 2'b01;
    localparam logic [1:0] CON_CFG = 2'b10;

endpackage

// File: rtl/dmac_run_watchdog.sv
// Channel-run watchdog: counts CH_RUN cycles and flags the last permitted one.
module dmac_run_watchdog #(
    parameter int unsigned TIMEOUT_W      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    // The counter reaches TIMEOUT_CYCLES on the edge leaving this cycle.
    assign expired = run && (count == LAST);

endmodule

// File: rtl/dmac_main_ctrl.sv
// DMA controller main FSM: config fetch over AHB, channel launch, completion.
// Optional run watchdog enabled by defining DMAC_RUN_TIMEOUT_EN.
module dmac_main_ctrl
    import dmac_pkg::*;
#(
    parameter int unsigned TIMEOUT_W      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] DmacReq,
    input  logic       HReady,
    input  logic [1:0] M_HResp,
    input  logic       irq,
    input  logic       C_config,
    output logic       channel_en_1,
    output logic       channel_en_2,
    output logic [1:0] con_sel,
    output logic       con_en,
    output logic [1:0] addr_inc_sel,
    output logic [1:0] config_HTrans,
    output logic       config_write,
    output logic       DmacReq_Reg_en,
    output logic       PeriAddr_reg_en,
    output logic       SAddr_Reg_en,
    output logic       DAddr_Reg_en,
    output logic       Trans_sz_Reg_en,
    output logic       Ctrl_Reg_en,
    output logic       done,
    output logic       err,
    output logic       busy
);

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic       ch2_sel, ch2_sel_nxt;
    logic       run_timeout;

`ifdef DMAC_RUN_TIMEOUT_EN
    dmac_run_watchdog #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_run_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_CH_START),
        .run     (state == ST_CH_RUN),
        .expired (run_timeout)
    );
`else
    logic [TIMEOUT_W-1:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_W'(TIMEOUT_CYCLES);
    assign run_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            ch2_sel <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            ch2_sel <= ch2_sel_nxt;
        end
    end

    assign config_write = 1'b0;
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        ch2_sel_nxt     = ch2_sel;
        con_sel         = CON_CFG;
        con_en          = 1'b0;
        addr_inc_sel    = IDX_SADDR;
        config_HTrans   = HTRANS_IDLE;
        channel_en_1    = 1'b0;
        channel_en_2    = 1'b0;
        DmacReq_Reg_en  = 1'b0;
        PeriAddr_reg_en = 1'b0;
        SAddr_Reg_en    = 1'b0;
        DAddr_Reg_en    = 1'b0;
        Trans_sz_Reg_en = 1'b0;
        Ctrl_Reg_en     = 1'b0;
        done            = 1'b0;
        err             = 1'b0;

        case (state)
            ST_IDLE: begin
                if (DmacReq != '0) begin
                    DmacReq_Reg_en  = 1'b1;
                    PeriAddr_reg_en = 1'b1;
                    idx_nxt         = '0;
                    state_nxt       = ST_LATCH;
                end
            end
            ST_LATCH: state_nxt = ST_CFG_ADDR;
            ST_CFG_ADDR: begin
                addr_inc_sel  = idx;
                config_HTrans = HTRANS_NONSEQ;
                if (HReady) state_nxt = ST_CFG_DATA;
            end
            ST_CFG_DATA: begin
                addr_inc_sel = idx;
                if (HReady && (M_HResp == HRESP_OKAY)) begin
                    case (idx)
                        IDX_SADDR: SAddr_Reg_en    = 1'b1;
                        IDX_DADDR: DAddr_Reg_en    = 1'b1;
                        IDX_SIZE:  Trans_sz_Reg_en = 1'b1;
                        default:   Ctrl_Reg_en     = 1'b1;
                    endcase
                    if (idx == IDX_CTRL) begin
                        state_nxt = ST_CH_START;
                    end else begin
                        idx_nxt   = idx + 2'd1;
                        state_nxt = ST_CFG_ADDR;
                    end
                end else if (M_HResp == HRESP_ERROR) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_CH_START: begin
                // Channel choice is latched here so CH_RUN ignores later C_config changes.
                con_sel     = C_config ? CON_CH2 : CON_CH1;
                con_en      = 1'b1;
                ch2_sel_nxt = C_config;
                state_nxt   = ST_CH_RUN;
            end
            ST_CH_RUN: begin
                con_sel      = ch2_sel ? CON_CH2 : CON_CH1;
                channel_en_1 = !ch2_sel;
                channel_en_2 = ch2_sel;
                if (irq) begin
                    state_nxt = ST_DONE;
                end else if (run_timeout) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                err       = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmac_main_ctrl.sv
// Self-checking bench for dmac_main_ctrl: per-cycle timeline model plus directed scenarios.
module tb_dmac_main_ctrl;

`ifdef DMAC_RUN_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1000;
`endif
    localparam int MAXC = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] DmacReq;
    logic       HReady;
    logic [1:0] M_HResp;
    logic       irq;
    logic       C_config;
    logic       channel_en_1, channel_en_2;
    logic [1:0] con_sel;
    logic       con_en;
    logic [1:0] addr_inc_sel;
    logic [1:0] config_HTrans;
    logic       config_write;
    logic       DmacReq_Reg_en, PeriAddr_reg_en;
    logic       SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en, Ctrl_Reg_en;
    logic       done, err, busy;

    dmac_main_ctrl #(
        .TIMEOUT_W      (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .DmacReq         (DmacReq),
        .HReady          (HReady),
        .M_HResp         (M_HResp),
        .irq             (irq),
        .C_config        (C_config),
        .channel_en_1    (channel_en_1),
        .channel_en_2    (channel_en_2),
        .con_sel         (con_sel),
        .con_en          (con_en),
        .addr_inc_sel    (addr_inc_sel),
        .config_HTrans   (config_HTrans),
        .config_write    (config_write),
        .DmacReq_Reg_en  (DmacReq_Reg_en),
        .PeriAddr_reg_en (PeriAddr_reg_en),
        .SAddr_Reg_en    (SAddr_Reg_en),
        .DAddr_Reg_en    (DAddr_Reg_en),
        .Trans_sz_Reg_en (Trans_sz_Reg_en),
        .Ctrl_Reg_en     (Ctrl_Reg_en),
        .done            (done),
        .err             (err),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction description and per-cycle stimulus/expectation tables.
    logic [1:0]  t_req;
    logic        t_cfg;
    int          t_aw[4];
    int          t_dw[4];
    int          t_err;
    int          t_irq;
    int          t_len, t_cs, t_endc;
    logic [17:0] exp_vec[MAXC];
    logic [17:0] obs_vec[MAXC];
    logic [1:0]  dq[MAXC];
    logic [1:0]  hp[MAXC];
    logic        hr[MAXC];
    logic        irq_d[MAXC];
    logic        cc[MAXC];

    // {busy,done,err,en1,en2,con_sel,con_en,addr_inc_sel,htrans,dreq_en,peri_en,ctrl,size,daddr,saddr}
    function automatic logic [17:0] mk(input logic b, input logic d, input logic e,
                                       input logic e1, input logic e2, input logic [1:0] cs,
                                       input logic ce, input logic [1:0] ai, input logic [1:0] ht,
                                       input logic dr, input logic [3:0] cap);
        return {b, d, e, e1, e2, cs, ce, ai, ht, dr, dr, cap};
    endfunction

    function automatic logic [17:0] pack_obs();
        return {busy, done, err, channel_en_1, channel_en_2, con_sel, con_en, addr_inc_sel,
                config_HTrans, DmacReq_Reg_en, PeriAddr_reg_en,
                Ctrl_Reg_en, Trans_sz_Reg_en, DAddr_Reg_en, SAddr_Reg_en};
    endfunction

    task automatic set_plain(input logic [1:0] req, input logic cfg, input int irq_delay);
        t_req = req;
        t_cfg = cfg;
        for (int i = 0; i < 4; i++) begin
            t_aw[i] = 0;
            t_dw[i] = 0;
        end
        t_err = -1;
        t_irq = irq_delay;
    endtask

    // Builds the expected timeline from phase lengths, then drives it and records outputs.
    task automatic run_txn();
        int  s, f;
        bit  aborted;
        logic [1:0] ch;
        for (int k = 0; k < MAXC; k++) begin
            exp_vec[k] = mk(0, 0, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 4'h0);
            hr[k]      = 1'($urandom_range(0, 1));
            hp[k]      = 2'($urandom_range(0, 3));
            irq_d[k]   = 1'($urandom_range(0, 1));
            cc[k]      = 1'($urandom_range(0, 1));
        end
        exp_vec[0] = mk(0, 0, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 1, 4'h0);
        exp_vec[1] = mk(1, 0, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 4'h0);
        s = 2;
        aborted = 0;
        t_cs = 0;
        t_endc = 0;
        for (int i = 0; i < 4 && !aborted; i++) begin
            for (int k = 0; k <= t_aw[i]; k++) begin
                exp_vec[s+k] = mk(1, 0, 0, 0, 0, 2'b10, 0, i[1:0], 2'b10, 0, 4'h0);
                hr[s+k] = (k == t_aw[i]);
            end
            f = s + t_aw[i] + 1 + t_dw[i];
            for (int k = s + t_aw[i] + 1; k <= f; k++) begin
                exp_vec[k] = mk(1, 0, 0, 0, 0, 2'b10, 0, i[1:0], 2'b00, 0, 4'h0);
                hr[k] = (k == f);
                hp[k] = 2'b00;
            end
            if (i == t_err) begin
                hp[f] = 2'b01;
                exp_vec[f+1] = mk(1, 0, 1, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 4'h0);
                t_endc = f + 1;
                aborted = 1;
            end else begin
                exp_vec[f][3:0] = 4'b0001 << i;
                s = f + 1;
            end
        end
        if (!aborted) begin
            t_cs = s;
            ch = t_cfg ? 2'b01 : 2'b00;
            cc[t_cs] = t_cfg;
            exp_vec[t_cs] = mk(1, 0, 0, 0, 0, ch, 1, 2'b00, 2'b00, 0, 4'h0);
            for (int k = 1; k <= ((t_irq >= TO) ? TO : t_irq + 1); k++) begin
                exp_vec[t_cs+k] = mk(1, 0, 0, !t_cfg, t_cfg, ch, 0, 2'b00, 2'b00, 0, 4'h0);
                irq_d[t_cs+k] = 1'b0;
            end
            if (t_irq < TO) begin
                irq_d[t_cs+1+t_irq] = 1'b1;
                t_endc = t_cs + 2 + t_irq;
                exp_vec[t_endc] = mk(1, 1, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 4'h0);
            end else begin
                t_endc = t_cs + 1 + TO;
                exp_vec[t_endc] = mk(1, 0, 1, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 4'h0);
            end
        end
        t_len = t_endc + 3;
        if (t_len > MAXC) begin
            $display("FAIL txn_length: got %0d cycles, limit %0d", t_len, MAXC);
            $fatal(1);
        end
        for (int k = 0; k < MAXC; k++)
            dq[k] = (k == 0) ? t_req : (k <= t_endc) ? 2'($urandom_range(0, 3)) : 2'b00;
        for (int k = 0; k < t_len; k++) begin
            DmacReq  = dq[k];
            HReady   = hr[k];
            M_HResp  = hp[k];
            irq      = irq_d[k];
            C_config = cc[k];
            #2;
            obs_vec[k] = pack_obs();
            @(posedge clk);
            #1;
        end
        DmacReq = 2'b00;
        irq     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        DmacReq = 2'b00; HReady = 1'b0; M_HResp = 2'b00; irq = 1'b0; C_config = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pack_obs() !== mk(0, 0, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 4'h0)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", pack_obs(),
                     mk(0, 0, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 0, 4'h0));
        end
        n_checks++;
        if (config_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_config_write: got %b expected 0", config_write);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_ch1_transfer();
        int first_en, cap_cyc[4];
        set_plain(2'b01, 1'b0, 3);
        run_txn();
        for (int k = 0; k < t_len; k++) begin
            n_checks++;
            if (obs_vec[k] !== exp_vec[k]) begin
                n_fail++;
                $display("FAIL ch1_cycle%0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
            end
        end
        first_en = -1;
        for (int i = 0; i < 4; i++) cap_cyc[i] = -1;
        for (int k = 0; k < t_len; k++) begin
            if (obs_vec[k][14] && first_en < 0) first_en = k;
            for (int i = 0; i < 4; i++)
                if (obs_vec[k][i] && cap_cyc[i] < 0) cap_cyc[i] = k;
        end
        n_checks++;
        if (first_en !== 11) begin
            n_fail++;
            $display("FAIL ch1_latency: got %0d expected 11", first_en);
        end
        n_checks++;
        if (cap_cyc[0] !== 3 || cap_cyc[1] !== 5 || cap_cyc[2] !== 7 || cap_cyc[3] !== 9) begin
            n_fail++;
            $display("FAIL ch1_capture_order: got %0d %0d %0d %0d expected 3 5 7 9",
                     cap_cyc[0], cap_cyc[1], cap_cyc[2], cap_cyc[3]);
        end
    endtask

    task automatic test_ch2_transfer();
        int en1_seen, en2_first;
        set_plain(2'b11, 1'b1, 5);
        run_txn();
        for (int k = 0; k < t_len; k++) begin
            n_checks++;
            if (obs_vec[k] !== exp_vec[k]) begin
                n_fail++;
                $display("FAIL ch2_cycle%0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
            end
        end
        en1_seen = 0;
        en2_first = -1;
        for (int k = 0; k < t_len; k++) begin
            if (obs_vec[k][14]) en1_seen++;
            if (obs_vec[k][13] && en2_first < 0) en2_first = k;
        end
        n_checks++;
        if (en1_seen !== 0 || en2_first !== 11) begin
            n_fail++;
            $display("FAIL ch2_enables: got en1_cycles=%0d en2_first=%0d expected 0 and 11",
                     en1_seen, en2_first);
        end
    endtask

    task automatic test_hready_stall();
        int sz_count;
        set_plain(2'b01, 1'b0, 1);
        t_dw[2] = 3;
        run_txn();
        for (int k = 0; k < t_len; k++) begin
            n_checks++;
            if (obs_vec[k] !== exp_vec[k]) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
            end
        end
        sz_count = 0;
        for (int k = 0; k < t_len; k++) if (obs_vec[k][2]) sz_count++;
        n_checks++;
        if (sz_count !== 1) begin
            n_fail++;
            $display("FAIL stall_size_en_count: got %0d expected 1", sz_count);
        end
    endtask

    task automatic test_hresp_error();
        int da_count, err_count;
        set_plain(2'b10, 1'b0, 0);
        t_err = 1;
        run_txn();
        da_count = 0;
        err_count = 0;
        for (int k = 0; k < t_len; k++) begin
            n_checks++;
            if (obs_vec[k] !== exp_vec[k]) begin
                n_fail++;
                $display("FAIL hresp_cycle%0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
            end
            if (obs_vec[k][1]) da_count++;
            if (obs_vec[k][15]) err_count++;
        end
        n_checks++;
        if (da_count !== 0 || err_count !== 1) begin
            n_fail++;
            $display("FAIL hresp_pulses: got daddr_en=%0d err=%0d expected 0 and 1", da_count, err_count);
        end
        set_plain(2'b01, 1'b1, 2);
        run_txn();
        for (int k = 0; k < t_len; k++) begin
            n_checks++;
            if (obs_vec[k] !== exp_vec[k]) begin
                n_fail++;
                $display("FAIL after_err_cycle%0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        HReady = 1'b1; M_HResp = 2'b00; irq = 1'b0; C_config = 1'b0;
        DmacReq = 2'b01;
        @(posedge clk); #1;
        DmacReq = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || config_HTrans !== 2'b00 || addr_inc_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_fetch: got busy=%b htrans=%b idx=%b expected 0 00 00",
                     busy, config_HTrans, addr_inc_sel);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        C_config = 1'b1;
        DmacReq = 2'b10;
        @(posedge clk); #1;
        DmacReq = 2'b00;
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (channel_en_2 !== 1'b1) begin
            n_fail++;
            $display("FAIL run_before_reset en2: got %b expected 1", channel_en_2);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (channel_en_1 !== 1'b0 || channel_en_2 !== 1'b0 || con_sel !== 2'b10 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_run: got en1=%b en2=%b con_sel=%b busy=%b expected 0 0 10 0",
                     channel_en_1, channel_en_2, con_sel, busy);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

`ifdef DMAC_RUN_TIMEOUT_EN
    task automatic test_timeout();
        int run_first, err_cyc;
        set_plain(2'b01, 1'b0, 20);
        run_txn();
        run_first = -1;
        err_cyc = -1;
        for (int k = 0; k < t_len; k++) begin
            n_checks++;
            if (obs_vec[k] !== exp_vec[k]) begin
                n_fail++;
                $display("FAIL timeout_cycle%0d: got %h expected %h", k, obs_vec[k], exp_vec[k]);
            end
            if (obs_vec[k][14] && run_first < 0) run_first = k;
            if (obs_vec[k][15] && err_cyc < 0) err_cyc = k;
        end
        n_checks++;
        if (err_cyc - run_first !== 8) begin
            n_fail++;
            $display("FAIL timeout_delay: got %0d expected 8", err_cyc - run_first);
        end
        set_plain(2'b01, 1'b1, 7);
        run_txn();
        n_checks++;
        if (obs_vec[t_endc][16] !== 1'b1 || obs_vec[t_endc][15] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_irq_wins: got done=%b err=%b expected 1 0",
                     obs_vec[t_endc][16], obs_vec[t_endc][15]);
        end
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            t_req = 2'($urandom_range(1, 3));
            t_cfg = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) begin
                t_aw[i] = $urandom_range(0, 3);
                t_dw[i] = $urandom_range(0, 3);
            end
            t_err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            t_irq = $urandom_range(0, 12);
            run_txn();
            for (int k = 0; k < t_len; k++) begin
                n_checks++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    n_fail++;
                    $display("FAIL random%0d_cycle%0d: got %h expected %h", n, k, obs_vec[k], exp_vec[k]);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ch1_transfer();
        test_ch2_transfer();
        test_hready_stall();
        test_hresp_error();
        test_async_reset();
`ifdef DMAC_RUN_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
